coded_block_pattern_encoding: RTL and testbench
===============================================

# coded_block_pattern_encoding

Encoder-side counterpart of the CBP decode path. It accepts one macroblock's CodedBlockPatternLuma/Chroma plus the macroblock class, maps the CBP to the me(v) codeNum (H.264 Table 9-4, chroma_format_idc=1), and serializes codeNum as an Exp-Golomb ue(v) codeword, one bit per cycle, over a valid/ready stream. It sits in the slice-data encoder between mode decision and the bitstream packer.

## Interface
- No parameters; bit widths fixed by the standard (codeNum 0..47, codeword ≤11 bits).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  CBP request valid
- in_ready  out  1  block can accept a request
- mb_type_general  in  4  [3]=1 Intra4x4, [3]=0 Inter; [3:2]=2'b10 Intra16x16
- CodedBlockPatternLuma  in  4  luma CBP bits
- CodedBlockPatternChroma  in  2  chroma CBP, 0..2
- bit_valid  out  1  serial bit valid
- bit_ready  in  1  downstream takes bit
- bit_out  out  1  codeword bit, MSB (first leading zero) first
- bit_last  out  1  marks final bit of codeword
- cbp_err  out  1  one-cycle pulse: chroma==3 request dropped
- bit_count  out  16  (only with macro) total bits emitted

## Operation
- FSM states: IDLE, PREFIX, INFO.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Intra16x16 ([3:2]==2'b10): request consumed, nothing emitted, stay IDLE.
  - Chroma==3: consumed, cbp_err pulses next cycle, stay IDLE.
  - Otherwise: codeNum = table[intra4x4][{chroma,luma}]; register v=codeNum+1 (6 bits), N=bit length of v minus 1 (0..5); go PREFIX if N>0, else INFO.
- PREFIX: bit_out=0; each handshake decrements zero counter; after N handshakes -> INFO.
- INFO: bit_out = v[i] for i=N down to 0; bit_last=1 when i==0; handshake on i==0 -> IDLE.
- Codeword length 2N+1 bits: 1 (codeNum 0) to 11 (codeNum 47).
- bit_valid=1 throughout PREFIX/INFO; bit_out/bit_last held stable while bit_valid&&!bit_ready.
- in_ready=0 outside IDLE; in_valid ignored there.

## Timing
- Reset values: in_ready=1 (after deassertion), bit_valid=0, bit_out=0, bit_last=0, cbp_err=0, bit_count=0, state IDLE.
- Accept at edge k -> first bit_valid in cycle k+1.
- After last handshake at edge m, in_ready=1 in cycle m+1; minimum request period = length+1 cycles.
- bit_ready low stalls indefinitely with no state change.
- Reset mid-codeword: immediate abort, partial codeword discarded, no bit_last emitted.

## Configuration
- CBP_ENC_BITCNT_EN defined: bit_count port present; increments by 1 per bit handshake, saturates at 16'hFFFF, cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package cbp_enc_pkg: two 48-entry 6-bit codeNum constant tables (intra4x4, inter) indexed {chroma[1:0],luma[3:0]}; FSM state encoding; Intra16x16 class constant. Tables are the exact inverse of the decoder's codeNum->CBP mapping.
- One sub-module: exp_golomb_ue_serializer (takes 6-bit codeNum + valid, emits ue(v) on bit stream); top does mapping, class filtering, error pulse, counter.

## Test plan
- Inter, luma 0 chroma 0 -> codeNum 0 -> single bit "1", bit_last on it, in_ready high next cycle.
- Intra4x4, luma 0 chroma 0 -> codeNum 3 -> "00100" (5 bits); Intra4x4 luma 15 chroma 2 -> "1".
- Inter, luma 15 chroma 2 -> codeNum 12 -> "0001101"; inter luma 9 chroma 2 -> codeNum 47 -> "00000110000" (11 bits), bit_last only on 11th.
- Random bit_ready throttling on 11-bit codeword -> identical bit sequence, outputs stable during stalls.
- Intra16x16 request -> no bit_valid; chroma=3 request -> cbp_err one-cycle pulse, no bits.
- Reset asserted after 3rd bit of 11-bit codeword -> bit_valid 0 immediately; next request encodes correctly; with CBP_ENC_BITCNT_EN, bit_count reads 0 after reset then equals bits emitted.

Source files
------------

// File: rtl/cbp_enc_pkg.sv
// Shared definitions for the coded block pattern encoder: CBP -> codeNum
// lookup tables (me(v) mapping for 4:2:0 / 4:2:2), serializer state
// encoding and the macroblock class constant used for filtering.
package cbp_enc_pkg;

    // Serializer FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        INFO   = 2'd2
    } ser_state_t;

    // mb_type_general[3:2] value that marks an Intra16x16 macroblock; its CBP
    // travels inside mb_type, so no me(v) codeword is produced for it.
    localparam logic [1:0] MB_CLASS_I16 = 2'b10;

    // CBP -> codeNum for Intra4x4/Intra8x8 macroblocks, indexed {chroma, luma}.
    localparam logic [5:0] CODE_INTRA [0:47] = '{
        6'd3,  6'd29, 6'd30, 6'd17, 6'd31, 6'd18, 6'd37, 6'd8,
        6'd32, 6'd38, 6'd19, 6'd9,  6'd20, 6'd10, 6'd11, 6'd2,
        6'd16, 6'd33, 6'd34, 6'd21, 6'd35, 6'd22, 6'd39, 6'd4,
        6'd36, 6'd40, 6'd23, 6'd5,  6'd24, 6'd6,  6'd7,  6'd1,
        6'd41, 6'd42, 6'd43, 6'd25, 6'd44, 6'd26, 6'd46, 6'd12,
        6'd45, 6'd47, 6'd27, 6'd13, 6'd28, 6'd14, 6'd15, 6'd0
    };

    // CBP -> codeNum for Inter macroblocks, indexed {chroma, luma}.
    localparam logic [5:0] CODE_INTER [0:47] = '{
        6'd0,  6'd2,  6'd3,  6'd7,  6'd4,  6'd8,  6'd17, 6'd13,
        6'd5,  6'd18, 6'd9,  6'd14, 6'd10, 6'd15, 6'd16, 6'd11,
        6'd1,  6'd32, 6'd33, 6'd36, 6'd34, 6'd37, 6'd44, 6'd40,
        6'd35, 6'd45, 6'd38, 6'd41, 6'd39, 6'd42, 6'd43, 6'd19,
        6'd6,  6'd24, 6'd25, 6'd20, 6'd26, 6'd21, 6'd46, 6'd28,
        6'd27, 6'd47, 6'd22, 6'd29, 6'd23, 6'd30, 6'd31, 6'd12
    };

    // Index of the most significant set bit (0 for an all-zero input).
    function automatic logic [2:0] msb_index(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/coded_block_pattern_encoding_serializer.sv
// Exp-Golomb ue(v) serializer: takes a 6-bit codeNum, emits N leading zeros
// followed by the N+1 bits of codeNum+1, MSB first, one bit per handshake.
module exp_golomb_ue_serializer
    import cbp_enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [5:0] code_num,
    output logic       code_ready,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_out,
    output logic       bit_last
);

    ser_state_t state_reg, state_next;
    logic [5:0] v_reg, v_next;       // codeNum + 1
    logic [2:0] n_reg, n_next;       // bit length of v minus one
    logic [2:0] cnt_reg, cnt_next;   // zeros left in PREFIX, bit index in INFO
    logic [5:0] v_in;
    logic [2:0] n_in;

    // codeNum 47 gives v = 48, which still fits in six bits
    assign v_in = code_num + 6'd1;
    assign n_in = msb_index(v_in);

    // State and codeword registers; reset aborts any codeword in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            v_reg     <= 6'd0;
            n_reg     <= 3'd0;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            v_reg     <= v_next;
            n_reg     <= n_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and output decode; outputs depend only on registered state,
    // so they hold steady while the downstream stalls
    always_comb begin
        state_next = state_reg;
        v_next     = v_reg;
        n_next     = n_reg;
        cnt_next   = cnt_reg;
        code_ready = 1'b0;
        bit_valid  = 1'b0;
        bit_out    = 1'b0;
        bit_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                code_ready = 1'b1;
                if (code_valid) begin
                    v_next     = v_in;
                    n_next     = n_in;
                    cnt_next   = n_in;
                    state_next = (n_in != 3'd0) ? PREFIX : INFO;
                end
            end
            PREFIX: begin
                bit_valid = 1'b1;
                if (bit_ready) begin
                    if (cnt_reg == 3'd1) begin
                        state_next = INFO;
                        cnt_next   = n_reg;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
            end
            INFO: begin
                bit_valid = 1'b1;
                bit_out   = v_reg[cnt_reg];
                bit_last  = (cnt_reg == 3'd0);
                if (bit_ready) begin
                    if (cnt_reg == 3'd0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/coded_block_pattern_encoding.sv
// Coded block pattern encoder: maps CBP to the me(v) codeNum and streams the
// ue(v) codeword. Intra16x16 requests are absorbed silently; chroma==3
// requests are dropped with a one-cycle cbp_err pulse.
// Optional: define CBP_ENC_BITCNT_EN to add the saturating bit_count output.
module coded_block_pattern_encoding
    import cbp_enc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  mb_type_general,
    input  logic [3:0]  CodedBlockPatternLuma,
    input  logic [1:0]  CodedBlockPatternChroma,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        bit_out,
    output logic        bit_last,
`ifdef CBP_ENC_BITCNT_EN
    output logic [15:0] bit_count,
`endif
    output logic        cbp_err
);

    logic       accept;
    logic       is_i16;
    logic       bad_chroma;
    logic [5:0] cbp_idx;
    logic [5:0] code_num;
    logic       code_valid;
    logic       cbp_err_reg;

    assign accept     = in_valid && in_ready;
    assign is_i16     = (mb_type_general[3:2] == MB_CLASS_I16);
    assign bad_chroma = (CodedBlockPatternChroma == 2'd3);
    // Keep the table index inside 0..47 even when the request is dropped
    assign cbp_idx    = bad_chroma ? 6'd0 : {CodedBlockPatternChroma, CodedBlockPatternLuma};
    assign code_num   = mb_type_general[3] ? CODE_INTRA[cbp_idx] : CODE_INTER[cbp_idx];
    assign code_valid = accept && !is_i16 && !bad_chroma;

    // Error pulse for an illegal chroma value, visible the cycle after accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cbp_err_reg <= 1'b0;
        end else begin
            cbp_err_reg <= accept && !is_i16 && bad_chroma;
        end
    end

    assign cbp_err = cbp_err_reg;

    exp_golomb_ue_serializer u_ser (
        .clk        (clk),
        .rst        (reset),
        .code_valid (code_valid),
        .code_num   (code_num),
        .code_ready (in_ready),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_out    (bit_out),
        .bit_last   (bit_last)
    );

`ifdef CBP_ENC_BITCNT_EN
    logic [15:0] bit_count_reg;

    // Saturating count of every bit handed downstream since reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count_reg <= 16'd0;
        end else if (bit_valid && bit_ready && (bit_count_reg != 16'hFFFF)) begin
            bit_count_reg <= bit_count_reg + 16'd1;
        end
    end

    assign bit_count = bit_count_reg;
`endif

endmodule

// File: tb/tb_coded_block_pattern_encoding.sv
// Scoreboard bench for coded_block_pattern_encoding: expected codeword bits
// are queued when a request is driven and compared as the DUT hands them out.
module tb_coded_block_pattern_encoding;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mb_type_general;
    logic [3:0]  CodedBlockPatternLuma;
    logic [1:0]  CodedBlockPatternChroma;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_out;
    logic        bit_last;
    logic        cbp_err;
`ifdef CBP_ENC_BITCNT_EN
    logic [15:0] bit_count;
`endif

    int n_checks = 0;
    int n_bad    = 0;
    int tb_bits  = 0;

    typedef struct packed {
        logic b;
        logic l;
    } exp_bit_t;

    exp_bit_t exp_q[$];

    // Standard table: codeNum -> CBP (chroma*16 + luma)
    int fwd_intra [0:47] = '{47,31,15,0,23,27,29,30,7,11,13,14,39,43,45,46,
                             16,3,5,10,12,19,21,26,28,35,37,42,44,1,2,4,
                             8,17,18,20,24,6,9,22,25,32,33,34,36,40,38,41};
    int fwd_inter [0:47] = '{0,16,1,2,4,8,32,3,5,10,12,15,47,7,11,13,
                             14,6,9,31,35,37,42,44,33,34,36,40,39,43,45,46,
                             17,18,20,24,19,21,26,28,23,27,29,30,22,25,38,41};

    localparam logic [3:0] MB_INTER = 4'b0000;
    localparam logic [3:0] MB_I4    = 4'b1100;
    localparam logic [3:0] MB_I16   = 4'b1000;

    coded_block_pattern_encoding dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .mb_type_general         (mb_type_general),
        .CodedBlockPatternLuma   (CodedBlockPatternLuma),
        .CodedBlockPatternChroma (CodedBlockPatternChroma),
        .bit_valid               (bit_valid),
        .bit_ready               (bit_ready),
        .bit_out                 (bit_out),
        .bit_last                (bit_last),
`ifdef CBP_ENC_BITCNT_EN
        .bit_count               (bit_count),
`endif
        .cbp_err                 (cbp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cbp_to_code(input logic intra, input int cbp);
        for (int c = 0; c < 48; c++) begin
            if ((intra ? fwd_intra[c] : fwd_inter[c]) == cbp) return c;
        end
        return -1;
    endfunction

    // Drive one request (caller is 1 time unit after a rising edge) and queue
    // the expected codeword; returns with the cycle after the accept edge.
    task automatic send(input logic [3:0] mbt, input logic [3:0] luma,
                        input logic [1:0] chroma, output int code);
        logic [5:0] v;
        int n;
        check("in_ready_before_req", in_ready, 1);
        code = -1;
        if (mbt[3:2] != 2'b10 && chroma != 2'd3) begin
            code = cbp_to_code(mbt[3], int'(chroma) * 16 + int'(luma));
            v = 6'(code + 1);
            n = 0;
            for (int i = 0; i < 6; i++) if (v[i]) n = i;
            for (int i = 0; i < n; i++) exp_q.push_back('{b: 1'b0, l: 1'b0});
            for (int i = n; i >= 0; i--) exp_q.push_back('{b: v[i], l: (i == 0)});
        end
        $display("req mb=%h luma=%0d chroma=%0d code=%0d bits=%0d",
                 mbt, luma, chroma, code, exp_q.size());
        in_valid = 1'b1;
        mb_type_general = mbt;
        CodedBlockPatternLuma = luma;
        CodedBlockPatternChroma = chroma;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Consume queued bits; random_rdy throttles bit_ready. limit < 0 drains all.
    task automatic drain(input bit random_rdy, input int limit);
        int cyc = 0;
        int taken = 0;
        bit stalled = 0;
        logic so, sl;
        exp_bit_t e;
        while (exp_q.size() > 0 && cyc < 300 && (limit < 0 || taken < limit)) begin
            if (stalled) begin
                check("stall_bit", bit_out, so);
                check("stall_last", bit_last, sl);
            end
            check("bit_valid_in_word", bit_valid, 1);
            bit_ready = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            check("in_ready_busy", in_ready, 0);
            if (bit_valid && bit_ready) begin
                e = exp_q.pop_front();
                check("bit_out", bit_out, e.b);
                check("bit_last", bit_last, e.l);
                taken++;
                tb_bits++;
                stalled = 0;
            end else begin
                stalled = 1;
                so = bit_out;
                sl = bit_last;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bit_ready = 1'b0;
        if (limit < 0) begin
            check("drain_left", exp_q.size(), 0);
            check("in_ready_after_word", in_ready, 1);
            check("bit_valid_after_word", bit_valid, 0);
        end
    endtask

    initial begin
        int code;
        reset = 1'b1;
        in_valid = 1'b0;
        bit_ready = 1'b0;
        mb_type_general = 4'd0;
        CodedBlockPatternLuma = 4'd0;
        CodedBlockPatternChroma = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_last", bit_last, 0);
        check("rst_cbp_err", cbp_err, 0);
`ifdef CBP_ENC_BITCNT_EN
        check("rst_bit_count", bit_count, 0);
`endif
        @(posedge clk);
        #1;

        // Directed codewords
        send(MB_INTER, 4'd0, 2'd0, code);  check("code_inter_0", code, 0);   drain(0, -1);
        send(MB_I4,    4'd0, 2'd0, code);  check("code_i4_0", code, 3);      drain(0, -1);
        send(MB_I4,    4'd15, 2'd2, code); check("code_i4_47", code, 0);     drain(0, -1);
        send(MB_INTER, 4'd15, 2'd2, code); check("code_inter_47", code, 12); drain(0, -1);
        send(MB_INTER, 4'd9, 2'd2, code);  check("code_inter_41", code, 47); drain(0, -1);
        // Same 11-bit codeword under random throttling
        send(MB_INTER, 4'd9, 2'd2, code);  drain(1, -1);

        // Random requests with random throttling
        for (int k = 0; k < 10; k++) begin
            send(($urandom_range(0, 1) != 0) ? MB_I4 : MB_INTER,
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), code);
            drain(1, -1);
        end

        // Intra16x16: absorbed, nothing emitted
        send(MB_I16, 4'd5, 2'd1, code);
        check("i16_no_valid", bit_valid, 0);
        check("i16_no_err", cbp_err, 0);
        check("i16_ready", in_ready, 1);
        @(posedge clk); #1;
        check("i16_no_valid_2", bit_valid, 0);

        // Chroma 3: dropped with a single-cycle error pulse
        send(MB_INTER, 4'd3, 2'd3, code);
        check("c3_err_pulse", cbp_err, 1);
        check("c3_no_valid", bit_valid, 0);
        @(posedge clk); #1;
        check("c3_err_clear", cbp_err, 0);
        check("c3_no_valid_2", bit_valid, 0);
        send(MB_I4, 4'd0, 2'd3, code);
        check("c3_i4_err_pulse", cbp_err, 1);
        @(posedge clk); #1;
        check("c3_i4_err_clear", cbp_err, 0);

`ifdef CBP_ENC_BITCNT_EN
        check("bit_count_total", bit_count, 32'(tb_bits));
`endif

        // Reset after the 3rd bit of an 11-bit codeword
        send(MB_INTER, 4'd9, 2'd2, code);
        drain(0, 3);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", bit_valid, 0);
        check("mid_rst_last", bit_last, 0);
        exp_q.delete();
        tb_bits = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_valid", bit_valid, 0);
`ifdef CBP_ENC_BITCNT_EN
        check("post_rst_bit_count", bit_count, 0);
`endif
        @(posedge clk); #1;
        send(MB_INTER, 4'd9, 2'd2, code);
        drain(0, -1);
        send(MB_INTER, 4'd15, 2'd2, code);
        drain(1, -1);
`ifdef CBP_ENC_BITCNT_EN
        check("bit_count_after_rst", bit_count, 32'(tb_bits));
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
